// File: rtl/friscv_pkg.sv
// Shared definitions for the Frisc-V multi-channel control unit:
// state encodings (which double as db_estado codes) and the dose counter width.
package friscv_pkg;

   localparam int CONT_W = 16;

   typedef enum logic [3:0] {
      INICIAL       = 4'b0000,
      ESPERA_ATIVAR = 4'b0001,
      BOMBA         = 4'b0010,
      FINAL         = 4'b0011,
      ABORTO        = 4'b0100,
      ESPERA_SOLTAR = 4'b0101
   } estado_t;

   localparam logic [3:0] DB_ILEGAL = 4'b1110;

endpackage

// File: rtl/friscv_uc_multi_if.sv
// Button/sensor and pump-driver signal bundle of the Frisc-V control unit.
// master: front-end side (drives buttons/sensor); slave: the control unit.
interface friscv_uc_multi_if #(
   parameter int N_SUCOS = 2
);
   localparam int SEL_W = (N_SUCOS > 1) ? $clog2(N_SUCOS) : 1;

   logic                        liga_frisc;
   logic [N_SUCOS-1:0]          liga_suco;
   logic                        copo_posicionado;
   logic [N_SUCOS-1:0]          ativa_bomba;
   logic                        inicia_medida;
   logic [SEL_W-1:0]            suco_sel;
   logic                        fim_dose;
   logic                        erro_copo;
   logic [friscv_pkg::CONT_W-1:0] doses_total;
   logic [3:0]                  db_estado;

   modport master (
      output liga_frisc, liga_suco, copo_posicionado,
      input  ativa_bomba, inicia_medida, suco_sel, fim_dose, erro_copo,
             doses_total, db_estado
   );

   modport slave (
      input  liga_frisc, liga_suco, copo_posicionado,
      output ativa_bomba, inicia_medida, suco_sel, fim_dose, erro_copo,
             doses_total, db_estado
   );

endinterface

// File: rtl/friscv_timer_dose.sv
// Per-dose pump-time counter. Counts cycles while enabled, holds at the limit,
// and flags expirou once DOSE_MAX_CICLOS-1 is reached.
module friscv_timer_dose #(
   parameter int DOSE_MAX_CICLOS = 50000000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expirou
);
   localparam int CW = (DOSE_MAX_CICLOS > 1) ? $clog2(DOSE_MAX_CICLOS) : 1;
   localparam logic [CW-1:0] LIMITE = CW'(DOSE_MAX_CICLOS - 1);

   logic [CW-1:0] cnt;

   assign expirou = (cnt == LIMITE);

   // Cycle counter, cleared at dose start, frozen at the limit
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && !expirou)
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/friscv_uc_multi.sv
// Frisc-V juice dispenser control unit, N channels.
// Optional completed-dose counter: define FRISCV_CONTADOR_DOSES_EN.
//
//   state         | meaning
//   INICIAL       | system off, sensor disabled
//   ESPERA_ATIVAR | armed, waiting for cup + button
//   BOMBA         | pump of suco_sel running
//   FINAL         | normal dose end, fim_dose pulse
//   ABORTO        | cup removed mid-dose, erro_copo set on exit
//   ESPERA_SOLTAR | waiting for all buttons released
module friscv_uc_multi
   import friscv_pkg::*;
#(
   parameter int N_SUCOS         = 2,
   parameter int DOSE_MAX_CICLOS = 50000000
) (
   input  logic              clock,
   input  logic              reset,
   friscv_uc_multi_if.slave  bus
);
   localparam int SEL_W = (N_SUCOS > 1) ? $clog2(N_SUCOS) : 1;

   estado_t          estado;
   logic [SEL_W-1:0] suco_sel;
   logic [SEL_W-1:0] sel_menor;
   logic             erro_copo;
   logic             expirou;
   logic             inicia_dose;
   logic             vai_final;

   // Lowest pressed button wins
   always_comb begin
      sel_menor = '0;
      for (int i = N_SUCOS - 1; i >= 0; i--)
         if (bus.liga_suco[i]) sel_menor = SEL_W'(i);
   end

   assign inicia_dose = (estado == ESPERA_ATIVAR) && bus.liga_frisc &&
                        bus.copo_posicionado && (bus.liga_suco != '0);
   assign vai_final   = (estado == BOMBA) && bus.copo_posicionado &&
                        (!bus.liga_suco[suco_sel] || !bus.liga_frisc || expirou);

   friscv_timer_dose #(.DOSE_MAX_CICLOS(DOSE_MAX_CICLOS)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (inicia_dose),
      .enable  (estado == BOMBA),
      .expirou (expirou)
   );

   // Main sequencing FSM with latched channel and sticky cup error
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado    <= INICIAL;
         suco_sel  <= '0;
         erro_copo <= 1'b0;
      end else begin
         case (estado)
            INICIAL:
               if (bus.liga_frisc) estado <= ESPERA_ATIVAR;
            ESPERA_ATIVAR:
               if (!bus.liga_frisc)
                  estado <= INICIAL;
               else if (inicia_dose) begin
                  suco_sel  <= sel_menor;
                  erro_copo <= 1'b0;
                  estado    <= BOMBA;
               end
            BOMBA:
               if (!bus.copo_posicionado)
                  estado <= ABORTO;
               else if (vai_final)
                  estado <= FINAL;
            FINAL:
               estado <= ESPERA_SOLTAR;
            ABORTO: begin
               erro_copo <= 1'b1;
               estado    <= ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR:
               if (!bus.liga_frisc)
                  estado <= INICIAL;
               else if (bus.liga_suco == '0)
                  estado <= ESPERA_ATIVAR;
            default:
               estado <= INICIAL;
         endcase
      end
   end

   // Debug code; anything outside the legal set reads as DB_ILEGAL
   always_comb begin
      case (estado)
         INICIAL, ESPERA_ATIVAR, BOMBA, FINAL, ABORTO, ESPERA_SOLTAR:
            bus.db_estado = estado;
         default:
            bus.db_estado = DB_ILEGAL;
      endcase
   end

   // Moore output decode from the state and channel registers
   always_comb begin
      bus.ativa_bomba = '0;
      if (estado == BOMBA) bus.ativa_bomba[suco_sel] = 1'b1;
   end

   assign bus.inicia_medida = (estado != INICIAL);
   assign bus.fim_dose      = (estado == FINAL);
   assign bus.suco_sel      = suco_sel;
   assign bus.erro_copo     = erro_copo;

`ifdef FRISCV_CONTADOR_DOSES_EN
   logic [CONT_W-1:0] doses;

   // Saturating count of normally completed doses
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         doses <= '0;
      else if (vai_final && (doses != '1))
         doses <= doses + CONT_W'(1);
   end

   assign bus.doses_total = doses;
`else
   assign bus.doses_total = '0;
`endif

endmodule
